// File: rtl/lbp_hist_pkg.sv
// ============================================================================
//  Module      : lbp_hist_pkg
//  Description : Shared types and constants for the riu2 LBP histogram block.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lbp_hist_pkg;

    // 4-bit bin index, wide enough for bins 0..9 plus the optional total beat
    typedef logic [3:0] bin_idx_t;

    localparam int       NUM_BINS    = 10;
    localparam bin_idx_t NONUNIF_BIN = 4'd9;

    // Histogram controller states
    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Number of set bits in an 8-bit code
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lbp_riu2_map.sv
// ============================================================================
//  Module      : lbp_riu2_map
//  Description : Combinational map from an 8-bit LBP code to its rotation-
//                invariant uniform (riu2) bin: uniform codes (at most two
//                circular 0/1 transitions) bin by their number of ones,
//                everything else lands in the non-uniform bin.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lbp_riu2_map
    import lbp_hist_pkg::*;
(
    input  logic [7:0] code,
    output bin_idx_t   bin
);

    logic [7:0] w_rot;
    logic [3:0] w_trans;
    logic [3:0] w_ones;

    // Circular transitions are the ones of code XOR (code rotated right by 1)
    assign w_rot   = {code[0], code[7:1]};
    assign w_trans = popcount8(code ^ w_rot);
    assign w_ones  = popcount8(code);
    assign bin     = (w_trans <= 4'd2) ? w_ones : NONUNIF_BIN;

endmodule

`default_nettype wire

// File: rtl/lbp_hist.sv
// ============================================================================
//  Module      : lbp_hist
//  Description : Snoops the LBP engine result-write bus, bins every written
//                code into a 10-bin riu2 histogram with saturating counters,
//                and on finish drains the bins over a valid/ready stream.
//                Optional macro LBP_HIST_TOTAL_EN adds a total-event beat
//                (hist_addr=10) and excludes image-border pixels from binning.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lbp_hist
    import lbp_hist_pkg::*;
#(
    parameter int CNT_W  = 7,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [ADDR_W-1:0] lbp_addr,
    input  logic              lbp_write,
    input  logic [7:0]        lbp_data,
    input  logic              finish,
    output logic              hist_valid,
    input  logic              hist_ready,
    output logic [3:0]        hist_addr,
    output logic [CNT_W-1:0]  hist_data,
    output logic              hist_done
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
`ifdef LBP_HIST_TOTAL_EN
    localparam bin_idx_t c_last_beat = 4'd10;
`else
    localparam bin_idx_t c_last_beat = NONUNIF_BIN;
`endif

    state_e           r_state;
    bin_idx_t         r_k;
    logic             r_wr_d;
    logic [CNT_W-1:0] r_bins [NUM_BINS];
    logic             w_event;
    logic             w_accept;
    logic             w_border;
    logic             w_bin_en;
    bin_idx_t         w_bin;
    logic [CNT_W-1:0] w_sel;

    lbp_riu2_map u_map (
        .code (lbp_data),
        .bin  (w_bin)
    );

    // Rising-edge detect of the write strobe: one count per strobe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_wr_d <= 1'b0;
        else        r_wr_d <= lbp_write;
    end

    // Only ACCUM counts; clear drops a coincident event
    assign w_event  = lbp_write & ~r_wr_d;
    assign w_accept = w_event & (r_state == ACCUM) & ~clear;
    assign w_bin_en = w_accept & ~w_border;

`ifdef LBP_HIST_TOTAL_EN
    logic [CNT_W-1:0] r_total;
    logic [2:0]       w_row;
    logic [2:0]       w_col;

    assign w_row    = lbp_addr[5:3];
    assign w_col    = lbp_addr[2:0];
    assign w_border = (w_row == 3'd0) | (w_row == 3'd7) |
                      (w_col == 3'd0) | (w_col == 3'd7);

    // Saturating count of every accepted event, border pixels included
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                 r_total <= '0;
        else if (clear)                             r_total <= '0;
        else if (w_accept && r_total != c_cnt_max)  r_total <= r_total + 1'b1;
    end
`else
    logic w_unused_addr;
    assign w_unused_addr = ^lbp_addr;
    assign w_border      = 1'b0;
`endif

    // Saturating bin counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_BINS; i++) r_bins[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < NUM_BINS; i++) r_bins[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_BINS; i++) begin
                if (w_bin_en && w_bin == 4'(i) && r_bins[i] != c_cnt_max)
                    r_bins[i] <= r_bins[i] + 1'b1;
            end
        end
    end

    // Controller: ACCUM -> DRAIN on finish, DRAIN -> DONE after the last beat
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ACCUM;
            r_k     <= '0;
        end else if (clear) begin
            r_state <= ACCUM;
            r_k     <= '0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (finish) begin
                        r_state <= DRAIN;
                        r_k     <= '0;
                    end
                end
                DRAIN: begin
                    if (hist_ready) begin
                        if (r_k == c_last_beat) begin
                            r_state <= DONE;
                            r_k     <= '0;
                        end else begin
                            r_k <= r_k + 4'd1;
                        end
                    end
                end
                DONE:    r_state <= DONE;
                default: r_state <= ACCUM;
            endcase
        end
    end

    // Beat payload selected by the current drain index
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_BINS; i++) begin
            if (r_k == 4'(i)) w_sel = r_bins[i];
        end
`ifdef LBP_HIST_TOTAL_EN
        if (r_k == c_last_beat) w_sel = r_total;
`endif
    end

    // Outputs decode straight from state so an async reset drops them at once
    assign hist_valid = (r_state == DRAIN);
    assign hist_done  = (r_state == DONE);
    assign hist_addr  = r_k;
    assign hist_data  = hist_valid ? w_sel : '0;

endmodule

`default_nettype wire

// File: tb/tb_lbp_hist.sv
// ============================================================================
//  Module      : tb_lbp_hist
//  Description : Directed self-checking bench for lbp_hist.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lbp_hist;

    localparam int CNT_W  = 7;
    localparam int ADDR_W = 6;
`ifdef LBP_HIST_TOTAL_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              clear;
    logic [ADDR_W-1:0] lbp_addr;
    logic              lbp_write;
    logic [7:0]        lbp_data;
    logic              finish;
    logic              hist_valid;
    logic              hist_ready;
    logic [3:0]        hist_addr;
    logic [CNT_W-1:0]  hist_data;
    logic              hist_done;

    int checks   = 0;
    int failures = 0;
    int exp_b [11];

    lbp_hist #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .lbp_addr   (lbp_addr),
        .lbp_write  (lbp_write),
        .lbp_data   (lbp_data),
        .finish     (finish),
        .hist_valid (hist_valid),
        .hist_ready (hist_ready),
        .hist_addr  (hist_addr),
        .hist_data  (hist_data),
        .hist_done  (hist_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", tag, act, expv);
        end
    endtask

    task automatic zero_exp();
        for (int i = 0; i < 11; i++) exp_b[i] = 0;
    endtask

    // One-cycle write strobe followed by one idle cycle
    task automatic strobe(input logic [7:0] code, input logic [ADDR_W-1:0] addr);
        @(negedge clk);
        lbp_addr  = addr;
        lbp_data  = code;
        lbp_write = 1'b1;
        @(negedge clk);
        lbp_write = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        finish = 1'b0;
        clear  = 1'b1;
        @(negedge clk);
        clear  = 1'b0;
    endtask

    // Accept every beat, holding ready low on drain cycles lo..hi (0-based)
    task automatic run_drain(input int lo, input int hi);
        int beat;
        int c;
        int guard;
        logic stalled;
        logic [3:0] pa;
        logic [CNT_W-1:0] pd;
        beat = 0; c = 0; guard = 0; stalled = 1'b0; pa = '0; pd = '0;
        while (beat < NB && guard < 100) begin
            @(negedge clk);
            guard++;
            if (hist_valid) begin
                if (stalled) begin
                    check_eq("hold_addr", 32'(hist_addr), 32'(pa));
                    check_eq("hold_data", 32'(hist_data), 32'(pd));
                end
                if (c >= lo && c <= hi) begin
                    hist_ready = 1'b0;
                    stalled    = 1'b1;
                    pa         = hist_addr;
                    pd         = hist_data;
                end else begin
                    hist_ready = 1'b1;
                    stalled    = 1'b0;
                    check_eq("beat_addr", 32'(hist_addr), 32'(beat));
                    check_eq($sformatf("bin%0d", beat), 32'(hist_data), 32'(exp_b[beat]));
                    beat++;
                end
                c++;
            end else begin
                hist_ready = 1'b0;
            end
        end
        check_eq("drain_beats", 32'(beat), 32'(NB));
        @(negedge clk);
        hist_ready = 1'b0;
        check_eq("post_valid", 32'(hist_valid), 32'd0);
        check_eq("post_done", 32'(hist_done), 32'd1);
    endtask

    initial begin
        int guard;
        reset = 1'b0; clear = 1'b0; lbp_addr = 6'd9; lbp_write = 1'b0;
        lbp_data = 8'h00; finish = 1'b0; hist_ready = 1'b0;

        // Reset state
        #3;
        check_eq("rst_valid", 32'(hist_valid), 32'd0);
        check_eq("rst_addr", 32'(hist_addr), 32'd0);
        check_eq("rst_data", 32'(hist_data), 32'd0);
        check_eq("rst_done", 32'(hist_done), 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;

        // Six codes, one per riu2 class of interest
        strobe(8'h00, 6'd9); strobe(8'hFF, 6'd9); strobe(8'h0F, 6'd9);
        strobe(8'h55, 6'd9); strobe(8'h01, 6'd9); strobe(8'h03, 6'd9);
        @(negedge clk); finish = 1'b1;
        zero_exp();
        exp_b[0] = 1; exp_b[1] = 1; exp_b[2] = 1; exp_b[4] = 1; exp_b[8] = 1; exp_b[9] = 1;
        exp_b[10] = 6;
        run_drain(-1, -1);
        // finish still high in DONE: no re-drain
        repeat (3) @(negedge clk);
        check_eq("done_hold_valid", 32'(hist_valid), 32'd0);
        check_eq("done_hold_done", 32'(hist_done), 32'd1);

        // clear returns to ACCUM
        pulse_clear();
        check_eq("clr_done", 32'(hist_done), 32'd0);
        check_eq("clr_valid", 32'(hist_valid), 32'd0);

        // Long strobe counts once; drain with backpressure on cycles 2-4
        @(negedge clk); lbp_data = 8'h00; lbp_write = 1'b1;
        repeat (3) @(negedge clk);
        lbp_write = 1'b0;
        @(negedge clk); finish = 1'b1;
        zero_exp(); exp_b[0] = 1; exp_b[10] = 1;
        run_drain(1, 3);

        // clear in ACCUM with a coincident strobe: strobe dropped
        pulse_clear();
        @(negedge clk); clear = 1'b1; lbp_data = 8'h00; lbp_write = 1'b1;
        @(negedge clk); clear = 1'b0; lbp_write = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("clrev_done", 32'(hist_done), 32'd0);
        check_eq("clrev_valid", 32'(hist_valid), 32'd0);
        finish = 1'b1;
        zero_exp();
        run_drain(-1, -1);

        // Saturation: 200 strobes of 0xFF
        pulse_clear();
        for (int i = 0; i < 200; i++) strobe(8'hFF, 6'd9);
        @(negedge clk); finish = 1'b1;
        zero_exp(); exp_b[8] = 127; exp_b[10] = 127;
        run_drain(-1, -1);

        // Async reset at beat 4 aborts the drain
        pulse_clear();
        strobe(8'h00, 6'd9); strobe(8'hFF, 6'd9);
        @(negedge clk); finish = 1'b1;
        zero_exp(); exp_b[0] = 1; exp_b[8] = 1;
        guard = 0;
        while (guard < 100) begin
            @(negedge clk);
            guard++;
            hist_ready = 1'b1;
            if (hist_valid && hist_addr == 4'd0)
                check_eq("abort_bin0", 32'(hist_data), 32'(exp_b[0]));
            if (hist_valid && hist_addr == 4'd4) break;
        end
        check_eq("abort_addr", 32'(hist_addr), 32'd4);
        #2 reset = 1'b0;
        #1;
        check_eq("abort_valid", 32'(hist_valid), 32'd0);
        check_eq("abort_raddr", 32'(hist_addr), 32'd0);
        @(negedge clk); reset = 1'b1; hist_ready = 1'b0;
        zero_exp();
        run_drain(-1, -1);

`ifdef LBP_HIST_TOTAL_EN
        // Full 8x8 frame of 0x00: only the 36 interior pixels are binned
        pulse_clear();
        for (int i = 0; i < 64; i++) strobe(8'h00, 6'(i));
        @(negedge clk); finish = 1'b1;
        zero_exp(); exp_b[0] = 36; exp_b[10] = 64;
        run_drain(-1, -1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lbp_hist.md
Name: lbp_hist

Overview:
- Downstream consumer of the LBP engine in the 8x8 LBP datapath.
- Snoops the engine's result-write bus (lbp_addr / lbp_write / lbp_data) in parallel with the LBP result memory.
- Bins each written code into a 10-bin rotation-invariant uniform (riu2) histogram.
- On the engine's finish, drains the histogram over a valid/ready stream to the feature stage.

Parameters:
- CNT_W, 7, bin counter width; counters saturate at 2^CNT_W-1.
- ADDR_W, 6, width of snooped lbp_addr (64-pixel image).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear: zero all bins, return to ACCUM.
- lbp_addr  in  ADDR_W  snooped result address; unused except in optional feature.
- lbp_write  in  1  snooped write strobe from the LBP engine.
- lbp_data  in  8  snooped LBP code.
- finish  in  1  LBP engine done; level, held high.
- hist_valid  out  1  bin output valid.
- hist_ready  in  1  downstream accept.
- hist_addr  out  4  bin index.
- hist_data  out  CNT_W  bin count.
- hist_done  out  1  drain complete; held high until clear or reset.

Behaviour:
- Reset (reset=0, asynchronous) drives the following values:
  - All bins = 0, state = ACCUM.
  - hist_valid = 0, hist_addr = 0, hist_data = 0, hist_done = 0.
  - Write-edge register wr_d = 0.
- Write detection:
  - wr_d registers lbp_write every cycle.
  - A sample event occurs on a cycle where lbp_write=1 and wr_d=0, i.e. one count per strobe regardless of strobe length.
  - lbp_data is sampled in that same cycle.
- riu2 mapping (combinational):
  - U = popcount(code XOR rotate_right(code,1)).
  - If U <= 2, bin = popcount(code) (0..8); otherwise bin = 9 (non-uniform).
- Update: the bin increments at the rising edge that detects the event, so the new count is visible 1 cycle later. A counter at max holds (saturates).
- FSM ACCUM:
  - Counts events.
  - finish=1 moves to DRAIN next cycle.
  - An event in the same cycle as finish is still counted.
- FSM DRAIN:
  - hist_valid=1, hist_addr=k, hist_data=bin[k], starting at k=0.
  - A beat transfers when hist_valid and hist_ready are both 1; k then increments.
  - hist_addr and hist_data stay stable while hist_ready=0.
  - Events during DRAIN are ignored.
  - After the beat with k=9 transfers: hist_valid=0 next cycle, state DONE.
- FSM DONE:
  - hist_done=1, bins are held, events are ignored.
  - finish is ignored in this state; no re-drain.
- clear, from any state:
  - Next cycle: bins = 0, k = 0, hist_valid = 0, hist_done = 0, state ACCUM.
  - clear beats an event in the same cycle; that event is dropped.
  - clear beats finish in the same cycle; the state stays in ACCUM.
- If finish is still high after clear, the next cycle goes to DRAIN. The controller deasserts finish before clear.
- Reset mid-DRAIN aborts immediately; no partial stream resumes.

Optional Feature:
- Macro: LBP_HIST_TOTAL_EN.
- Defined:
  - Adds an 11th beat, hist_addr=10, carrying the total event count (CNT_W bits, saturating).
  - Also adds a write-address check: an event whose lbp_addr lies on the image border (row or column 0 or 7) is not binned but is counted in the total.
  - DONE is entered after beat 10.
- Not defined: exactly 10 beats; every event is binned; no total counter or border logic is synthesized.

Decomposition:
- Package lbp_hist_pkg contains:
  - NUM_BINS = 10 and NONUNIF_BIN = 9.
  - State enum {ACCUM, DRAIN, DONE}.
  - Bin-index type logic [3:0].
- Sub-module lbp_riu2_map (pure combinational: 8-bit code -> 4-bit bin), separately unit-testable.

Test Plan:
- Reset then codes 0x00, 0xFF, 0x0F, 0x55, 0x01, 0x03 with finish=1 and hist_ready=1:
  - Drain gives bin0=1, bin1=1, bin2=1, bin4=1, bin8=1, bin9=1, others 0.
  - hist_done=1 one cycle after beat 9.
- lbp_write held high 3 cycles with code 0x00: bin0=1, not 3.
- Backpressure: hist_ready low on cycles 2-4 of the drain:
  - hist_addr/hist_data hold during the stall.
  - 10 beats arrive in order 0..9; no duplicate or missing beat.
- 200 strobes of 0xFF: bin8 saturates at 127.
- clear asserted with a strobe of 0x00 in the same cycle: bin0 stays 0; state ACCUM; hist_done=0.
- reset=0 asynchronously mid-DRAIN at beat 4:
  - hist_valid drops without waiting for a clock edge.
  - Bins read 0 after a new finish.
- LBP_HIST_TOTAL_EN: full 8x8 run writing all 64 addresses with 0x00:
  - bin0=36 (interior pixels only).
  - Beat 10 = 64.
